// File: rtl/mint_ctrl_if.sv
// CSR access, interrupt sources and trap-unit handshake for mint_ctrl.
// The controller sits on the slave side; the hart/trap unit drives the master side.
interface mint_ctrl_if #(
  parameter int NUM_LOCAL = 4
);
  logic [11:0]          csr_addr_in;
  logic                 wr_en_in;
  logic [1:0]           csr_op_in;
  logic [31:0]          data_wr_in;
  logic                 mext_irq_in;
  logic                 mtimer_irq_in;
  logic                 msoft_irq_in;
  logic [NUM_LOCAL-1:0] local_irq_in;
  logic                 mstatus_mie_in;
  logic                 ack_in;
  logic [31:0]          mie_reg_out;
  logic [31:0]          mip_reg_out;
  logic                 irq_req_out;
  logic [4:0]           irq_cause_out;

  modport slave (
    input  csr_addr_in, wr_en_in, csr_op_in, data_wr_in,
    input  mext_irq_in, mtimer_irq_in, msoft_irq_in, local_irq_in,
    input  mstatus_mie_in, ack_in,
    output mie_reg_out, mip_reg_out, irq_req_out, irq_cause_out
  );

  modport master (
    output csr_addr_in, wr_en_in, csr_op_in, data_wr_in,
    output mext_irq_in, mtimer_irq_in, msoft_irq_in, local_irq_in,
    output mstatus_mie_in, ack_in,
    input  mie_reg_out, mip_reg_out, irq_req_out, irq_cause_out
  );
endinterface

// File: rtl/mint_ctrl.sv
// Machine-mode interrupt enable/pending controller: mie/mip CSRs, level/edge
// capture of local sources, fixed-priority selection and a registered request.
module mint_ctrl #(
  parameter int                   NUM_LOCAL = 4,
  parameter logic [NUM_LOCAL-1:0] EDGE_MASK = '0,
  parameter logic [11:0]          MIE       = 12'h304,
  parameter logic [11:0]          MIP       = 12'h344
) (
  input  logic        clock,
  input  logic        rst_in,
  mint_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [31:0] STD_BITS   = 32'h0000_0888;
  localparam logic [31:0] LOCAL_BITS = 32'((((64'd1 << NUM_LOCAL) - 64'd1) << 16));
  localparam logic [31:0] MIE_MASK   = STD_BITS | LOCAL_BITS;

  logic [31:0]          mie_q, mie_d;
  logic                 ext_q, timer_q, soft_q;
  logic [NUM_LOCAL-1:0] local_q, local_d, prev_q, edge_clr;
  logic                 req_q;
  logic [4:0]           cause_q;
  logic [31:0]          mip_vec, cand;
  logic                 any_cand;
  logic [4:0]           best_cause;
  logic                 ack_ok, mie_wr, mip_wr;
  csr_op_e              op;

  assign op     = csr_op_e'(bus.csr_op_in);
  assign mie_wr = bus.wr_en_in && (bus.csr_addr_in == MIE);
  assign mip_wr = bus.wr_en_in && (bus.csr_addr_in == MIP);
  assign ack_ok = bus.ack_in && req_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    mie_d = mie_q;
    if (mie_wr) begin
      unique case (op)
        OP_WRITE: mie_d = bus.data_wr_in & MIE_MASK;
        OP_SET:   mie_d = mie_q | (bus.data_wr_in & MIE_MASK);
        OP_CLEAR: mie_d = mie_q & ~bus.data_wr_in;
        default:  mie_d = mie_q;
      endcase
    end
  end

  // Edge bits are sticky; a new edge in the same cycle as a clear still wins.
  always_comb begin
    edge_clr = '0;
    local_d  = bus.local_irq_in;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      if (EDGE_MASK[i]) begin
        edge_clr[i] = (mip_wr && op == OP_CLEAR &&  bus.data_wr_in[16+i]) ||
                      (mip_wr && op == OP_WRITE && !bus.data_wr_in[16+i]) ||
                      (ack_ok && cause_q == 5'(16 + i));
        local_d[i]  = (bus.local_irq_in[i] & ~prev_q[i]) | (local_q[i] & ~edge_clr[i]);
      end
    end
  end

  always_comb begin
    mip_vec                   = '0;
    mip_vec[11]               = ext_q;
    mip_vec[7]                = timer_q;
    mip_vec[3]                = soft_q;
    mip_vec[16 +: NUM_LOCAL]  = local_q;
  end

  assign cand = mip_vec & mie_q & {32{bus.mstatus_mie_in}};

  // Later assignments override earlier ones, so they run lowest priority first.
  always_comb begin
    any_cand   = 1'b0;
    best_cause = cause_q;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      if (cand[16+i]) begin
        any_cand   = 1'b1;
        best_cause = 5'(16 + i);
      end
    end
    if (cand[7])  begin any_cand = 1'b1; best_cause = 5'd7;  end
    if (cand[3])  begin any_cand = 1'b1; best_cause = 5'd3;  end
    if (cand[11]) begin any_cand = 1'b1; best_cause = 5'd11; end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (rst_in) begin
      mie_q   <= '0;
      ext_q   <= 1'b0;
      timer_q <= 1'b0;
      soft_q  <= 1'b0;
      local_q <= '0;
      prev_q  <= '0;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      mie_q   <= mie_d;
      ext_q   <= bus.mext_irq_in;
      timer_q <= bus.mtimer_irq_in;
      soft_q  <= bus.msoft_irq_in;
      local_q <= local_d;
      prev_q  <= bus.local_irq_in;
      if (ack_ok) begin
        req_q <= 1'b0;
      end else begin
        req_q <= any_cand;
        if (any_cand) cause_q <= best_cause;
      end
    end
  end

  assign bus.mie_reg_out   = mie_q;
  assign bus.mip_reg_out   = mip_vec;
  assign bus.irq_req_out   = req_q;
  assign bus.irq_cause_out = cause_q;

endmodule

// File: tb/tb_mint_ctrl.sv
// Randomised and directed bench for mint_ctrl, compared cycle by cycle against
// a behavioural model of the mie/mip rules and fixed interrupt priority.
module tb_mint_ctrl;
  localparam int          NL        = 4;
  localparam logic [NL-1:0] EMASK   = 4'b0001;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MIP     = 12'h344;
  localparam logic [31:0] IMPL      = 32'h000F_0888;

  logic clock;
  logic rst_in;
  int   errors = 0;
  int   checks = 0;

  mint_ctrl_if #(.NUM_LOCAL(NL)) bus ();

  mint_ctrl #(.NUM_LOCAL(NL), .EDGE_MASK(EMASK)) dut (
    .clock  (clock),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model state
  logic [31:0] m_mie, m_mip;
  logic [NL-1:0] m_prev;
  logic        m_req;
  logic [4:0]  m_cause;
  int          prio [7] = '{11, 3, 7, 19, 18, 17, 16};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [31:0] n_mie, n_mip, cand;
    logic        honoured, found, clr;
    logic [4:0]  n_cause;
    honoured = bus.ack_in && m_req;
    n_mie = m_mie;
    if (bus.wr_en_in && bus.csr_addr_in == A_MIE) begin
      case (bus.csr_op_in)
        2'b01:   n_mie = bus.data_wr_in & IMPL;
        2'b10:   n_mie = m_mie | (bus.data_wr_in & IMPL);
        2'b11:   n_mie = m_mie & ~bus.data_wr_in;
        default: n_mie = m_mie;
      endcase
    end
    n_mip = '0;
    n_mip[11] = bus.mext_irq_in;
    n_mip[7]  = bus.mtimer_irq_in;
    n_mip[3]  = bus.msoft_irq_in;
    for (int i = 0; i < NL; i++) begin
      if (EMASK[i]) begin
        clr = (bus.wr_en_in && bus.csr_addr_in == A_MIP &&
               ((bus.csr_op_in == 2'b11 && bus.data_wr_in[16+i]) ||
                (bus.csr_op_in == 2'b01 && !bus.data_wr_in[16+i]))) ||
              (honoured && int'(m_cause) == 16 + i);
        n_mip[16+i] = (bus.local_irq_in[i] && !m_prev[i]) || (m_mip[16+i] && !clr);
      end else begin
        n_mip[16+i] = bus.local_irq_in[i];
      end
    end
    cand = m_mip & m_mie & {32{bus.mstatus_mie_in}};
    found = 1'b0;
    n_cause = m_cause;
    for (int k = 0; k < 7; k++) begin
      if (!found && cand[prio[k]]) begin
        found = 1'b1;
        n_cause = 5'(prio[k]);
      end
    end
    if (honoured) begin
      found = 1'b0;
      n_cause = m_cause;
    end
    @(posedge clock);
    #1;
    if (rst_in) begin
      m_mie = '0; m_mip = '0; m_prev = '0; m_req = 1'b0; m_cause = '0;
    end else begin
      m_mie = n_mie; m_mip = n_mip; m_prev = bus.local_irq_in;
      m_req = found; m_cause = n_cause;
    end
    check("mie_model",   bus.mie_reg_out, m_mie);
    check("mip_model",   bus.mip_reg_out, m_mip);
    check("req_model",   32'(bus.irq_req_out), 32'(m_req));
    check("cause_model", 32'(bus.irq_cause_out), 32'(m_cause));
  endtask

  task automatic csr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    bus.wr_en_in    = 1'b1;
    bus.csr_addr_in = addr;
    bus.csr_op_in   = op;
    bus.data_wr_in  = data;
    step();
    bus.wr_en_in    = 1'b0;
    bus.csr_op_in   = 2'b00;
  endtask

  initial begin
    m_mie = '0; m_mip = '0; m_prev = '0; m_req = 1'b0; m_cause = '0;
    rst_in = 1'b1;
    bus.csr_addr_in = '0; bus.wr_en_in = 1'b0; bus.csr_op_in = '0; bus.data_wr_in = '0;
    bus.mext_irq_in = 1'b0; bus.mtimer_irq_in = 1'b0; bus.msoft_irq_in = 1'b0;
    bus.local_irq_in = '0; bus.mstatus_mie_in = 1'b0; bus.ack_in = 1'b0;
    step();
    step();
    check("reset_mie", bus.mie_reg_out, 32'h0);
    check("reset_req", 32'(bus.irq_req_out), 32'h0);
    rst_in = 1'b0;

    // mie implemented bits and clear op
    csr(A_MIE, 2'b01, 32'hFFFF_FFFF);
    check("mie_write_all", bus.mie_reg_out, 32'h000F_0888);
    csr(A_MIE, 2'b11, 32'h0000_0800);
    check("mie_clear_meie", bus.mie_reg_out, 32'h000F_0088);

    // Timer latency: mip after N, request after N+1
    csr(A_MIE, 2'b01, 32'h0000_0080);
    bus.mstatus_mie_in = 1'b1;
    bus.mtimer_irq_in  = 1'b1;
    step();
    check("mtip_set", 32'(bus.mip_reg_out[7]), 32'h1);
    check("mtip_req_lat", 32'(bus.irq_req_out), 32'h0);
    step();
    check("mti_req", 32'(bus.irq_req_out), 32'h1);
    check("mti_cause", 32'(bus.irq_cause_out), 32'd7);

    // Priority ladder
    csr(A_MIE, 2'b01, 32'hFFFF_FFFF);
    bus.mext_irq_in = 1'b1; bus.msoft_irq_in = 1'b1; bus.local_irq_in = 4'b1000;
    step(); step();
    check("prio_mei", 32'(bus.irq_cause_out), 32'd11);
    bus.mext_irq_in = 1'b0;
    step(); step();
    check("prio_msi", 32'(bus.irq_cause_out), 32'd3);
    bus.msoft_irq_in = 1'b0;
    step(); step();
    check("prio_mti", 32'(bus.irq_cause_out), 32'd7);
    bus.mtimer_irq_in = 1'b0;
    step(); step();
    check("prio_local3", 32'(bus.irq_cause_out), 32'd19);
    bus.local_irq_in = '0;
    step(); step();
    check("level_withdraw", 32'(bus.irq_req_out), 32'h0);

    // Edge capture, ack clear, CSR set ignored
    bus.local_irq_in = 4'b0001;
    step();
    bus.local_irq_in = 4'b0000;
    step();
    check("edge_sticky", 32'(bus.mip_reg_out[16]), 32'h1);
    check("edge_cause", 32'(bus.irq_cause_out), 32'd16);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    check("ack_clears_edge", 32'(bus.mip_reg_out[16]), 32'h0);
    check("ack_drops_req", 32'(bus.irq_req_out), 32'h0);
    csr(A_MIP, 2'b10, 32'h0001_0000);
    check("mip_set_ignored", 32'(bus.mip_reg_out[16]), 32'h0);

    // New edge beats simultaneous CSR clear
    bus.local_irq_in = 4'b0001;
    step();
    bus.local_irq_in = 4'b0000;
    step();
    bus.local_irq_in = 4'b0001;
    csr(A_MIP, 2'b11, 32'h0001_0000);
    bus.local_irq_in = 4'b0000;
    check("set_beats_clear", 32'(bus.mip_reg_out[16]), 32'h1);

    // Ack with request low is ignored
    bus.mstatus_mie_in = 1'b0;
    step();
    check("gated_req", 32'(bus.irq_req_out), 32'h0);
    check("cause_held", 32'(bus.irq_cause_out), 32'd16);
    bus.ack_in = 1'b1;
    step();
    bus.ack_in = 1'b0;
    check("ack_ignored", 32'(bus.mip_reg_out[16]), 32'h1);
    bus.mstatus_mie_in = 1'b1;
    step(); step();
    check("req_before_rst", 32'(bus.irq_req_out), 32'h1);

    // Reset mid-request
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check("rst_mie", bus.mie_reg_out, 32'h0);
    check("rst_mip", bus.mip_reg_out, 32'h0);
    check("rst_req", 32'(bus.irq_req_out), 32'h0);
    check("rst_cause", 32'(bus.irq_cause_out), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [1:0] asel;
      rst_in = ($urandom_range(0, 99) == 0);
      bus.wr_en_in = ($urandom_range(0, 3) == 0);
      asel = 2'($urandom_range(0, 2));
      bus.csr_addr_in = (asel == 0) ? A_MIE : (asel == 1) ? A_MIP : 12'h300;
      bus.csr_op_in = 2'($urandom);
      bus.data_wr_in = $urandom;
      if ($urandom_range(0, 3) == 0) bus.mext_irq_in   = ~bus.mext_irq_in;
      if ($urandom_range(0, 3) == 0) bus.mtimer_irq_in = ~bus.mtimer_irq_in;
      if ($urandom_range(0, 3) == 0) bus.msoft_irq_in  = ~bus.msoft_irq_in;
      if ($urandom_range(0, 2) == 0) bus.local_irq_in  = 4'($urandom);
      bus.mstatus_mie_in = ($urandom_range(0, 7) != 0);
      bus.ack_in = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
